// File: rtl/alu_mem_stage.sv
// Execute/memory stage: ALUOp decode, 16-bit ALU, and a byte-addressable
// big-endian data memory addressed by the ALU result.
module alu_mem_stage #(
  parameter int ADDR_WIDTH = 7
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [1:0]  ALUOp,
  input  logic [1:0]  Funct,
  input  logic [3:0]  Opcode,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  input  logic [15:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [3:0]  ALUCtrl,
  output logic [15:0] Result,
  output logic        Zero,
  output logic        Overflow,
  output logic        CarryOut,
  output logic [15:0] ReadData
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [3:0]            alu_ctrl_s;
  logic [15:0]           a_s;
  logic [15:0]           b_s;
  logic [16:0]           sum_s;
  logic                  add_ovf_s;
  logic [15:0]           result_s;
  logic                  ovf_s;
  logic                  carry_s;
  logic [ADDR_WIDTH-1:0] ea_hi_s;
  logic [ADDR_WIDTH-1:0] ea_lo_s;
  logic [15:0]           read_data_s;
  logic [7:0]            mem_r [DEPTH];

  // Control decode: ALU class plus funct/opcode into the ALU control word.
  always_comb begin
    alu_ctrl_s = 4'b0010;
    case (ALUOp)
      2'b00: alu_ctrl_s = 4'b0010;
      2'b01: alu_ctrl_s = 4'b0110;
      2'b10: begin
        case (Funct)
          2'b00:   alu_ctrl_s = 4'b0010;
          2'b01:   alu_ctrl_s = 4'b0110;
          2'b10:   alu_ctrl_s = 4'b0000;
          2'b11:   alu_ctrl_s = 4'b0001;
          default: alu_ctrl_s = 4'b0010;
        endcase
      end
      2'b11: begin
        case (Opcode)
          4'b0100: alu_ctrl_s = 4'b0010;
          4'b0101: alu_ctrl_s = 4'b0111;
          4'b0110: alu_ctrl_s = 4'b0000;
          4'b0111: alu_ctrl_s = 4'b0001;
          default: alu_ctrl_s = 4'b0010;
        endcase
      end
      default: alu_ctrl_s = 4'b0010;
    endcase
  end

  // ALU: shared adder with optional operand inversion; SLT folds in overflow
  // so the sign test is a correct signed compare.
  always_comb begin
    a_s       = alu_ctrl_s[3] ? ~A : A;
    b_s       = alu_ctrl_s[2] ? ~B : B;
    sum_s     = {1'b0, a_s} + {1'b0, b_s} + {16'h0000, (alu_ctrl_s[2] | Cin)};
    add_ovf_s = (a_s[15] == b_s[15]) && (sum_s[15] != a_s[15]);
    result_s  = 16'h0000;
    ovf_s     = 1'b0;
    carry_s   = 1'b0;
    case (alu_ctrl_s)
      4'b0000, 4'b1100: result_s = a_s & b_s;
      4'b0001:          result_s = a_s | b_s;
      4'b0010, 4'b0110: begin
        result_s = sum_s[15:0];
        ovf_s    = add_ovf_s;
        carry_s  = sum_s[16];
      end
      4'b0111: begin
        result_s = {15'h0000, sum_s[15] ^ add_ovf_s};
        carry_s  = sum_s[16];
      end
      default: result_s = 16'h0000;
    endcase
  end

  assign ALUCtrl  = alu_ctrl_s;
  assign Result   = result_s;
  assign Zero     = (result_s == 16'h0000);
  assign Overflow = ovf_s;
  assign CarryOut = carry_s;

  // Word-aligned effective address; upper result bits wrap.
  assign ea_hi_s = {result_s[ADDR_WIDTH-1:1], 1'b0};
  assign ea_lo_s = {result_s[ADDR_WIDTH-1:1], 1'b1};

  // Data memory: big-endian byte pair write, cleared asynchronously on reset.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (MemWrite) begin
      mem_r[ea_hi_s] <= WriteData[15:8];
      mem_r[ea_lo_s] <= WriteData[7:0];
    end
  end

  // Combinational read port, gated by MemRead and held at zero in reset.
  always_comb begin
    if (MemRead && Reset_n) begin
      read_data_s = {mem_r[ea_hi_s], mem_r[ea_lo_s]};
    end else begin
      read_data_s = 16'h0000;
    end
  end

  assign ReadData = read_data_s;

endmodule

// File: tb/tb_alu_mem_stage.sv
// Scoreboard bench for alu_mem_stage: directed vectors plus random traffic
// checked against an arithmetic reference model.
module tb_alu_mem_stage;
  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic [1:0]  ALUOp = 2'd0;
  logic [1:0]  Funct = 2'd0;
  logic [3:0]  Opcode = 4'd0;
  logic [15:0] A = 16'd0;
  logic [15:0] B = 16'd0;
  logic        Cin = 1'b0;
  logic [15:0] WriteData = 16'd0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [3:0]  ALUCtrl;
  logic [15:0] Result;
  logic        Zero;
  logic        Overflow;
  logic        CarryOut;
  logic [15:0] ReadData;

  alu_mem_stage #(.ADDR_WIDTH(7)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .ALUOp(ALUOp), .Funct(Funct),
    .Opcode(Opcode), .A(A), .B(B), .Cin(Cin), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ALUCtrl(ALUCtrl),
    .Result(Result), .Zero(Zero), .Overflow(Overflow), .CarryOut(CarryOut),
    .ReadData(ReadData)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [15:0] res;
    logic        zero;
    logic        ovf;
    logic        carry;
    logic [15:0] rd;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] ref_mem [128];
  logic       rst_cmd = 1'b0;
  int         total = 0;
  int         bad = 0;

  function automatic logic [3:0] ref_ctrl(logic [1:0] op, logic [1:0] fn, logic [3:0] opc);
    logic [3:0] rf [4];
    rf[0] = 4'b0010; rf[1] = 4'b0110; rf[2] = 4'b0000; rf[3] = 4'b0001;
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b10) return rf[fn];
    if (opc == 4'd5) return 4'b0111;
    if (opc == 4'd6) return 4'b0000;
    if (opc == 4'd7) return 4'b0001;
    return 4'b0010;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives one cycle of stimulus just after the rising edge and queues the
  // expected outputs computed from plain arithmetic.
  task automatic txn(string nm, logic [1:0] op, logic [1:0] fn, logic [3:0] opc,
                     logic [15:0] a, logic [15:0] b, logic cin,
                     logic [15:0] wd, logic mr, logic mw);
    exp_t e;
    int   sa, sb, s;
    longint ua, ub, tot;
    int   ea;
    @(posedge Clock);
    #1;
    Reset_n = rst_cmd; ALUOp = op; Funct = fn; Opcode = opc; A = a; B = b;
    Cin = cin; WriteData = wd; MemRead = mr; MemWrite = mw;
    if (!rst_cmd) foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    e.name = nm; e.ctrl = ref_ctrl(op, fn, opc);
    e.ovf = 1'b0; e.carry = 1'b0; e.res = 16'h0000;
    case (e.ctrl)
      4'b0010: begin
        tot = ua + ub + cin; e.res = tot[15:0]; e.carry = (tot >= 65536);
        s = sa + sb + cin; e.ovf = (s > 32767) || (s < -32768);
      end
      4'b0110: begin
        e.res = a - b; e.carry = (ua >= ub);
        s = sa - sb; e.ovf = (s > 32767) || (s < -32768);
      end
      4'b0111: begin
        e.res = (sa < sb) ? 16'd1 : 16'd0; e.carry = (ua >= ub);
      end
      4'b0000: e.res = a & b;
      4'b0001: e.res = a | b;
      default: e.res = 16'h0000;
    endcase
    e.zero = (e.res == 16'h0000);
    ea = (int'(e.res) % 128) & ~1;
    e.rd = (mr && rst_cmd) ? {ref_mem[ea], ref_mem[ea + 1]} : 16'h0000;
    if (mw && rst_cmd) begin
      ref_mem[ea] = wd[15:8];
      ref_mem[ea + 1] = wd[7:0];
    end
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are combinational, so compare mid-cycle on the falling edge.
  always @(negedge Clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk({e.name, ".ctrl"},  {12'd0, ALUCtrl},  {12'd0, e.ctrl});
      chk({e.name, ".res"},   Result,            e.res);
      chk({e.name, ".zero"},  {15'd0, Zero},     {15'd0, e.zero});
      chk({e.name, ".ovf"},   {15'd0, Overflow}, {15'd0, e.ovf});
      chk({e.name, ".carry"}, {15'd0, CarryOut}, {15'd0, e.carry});
      chk({e.name, ".rd"},    ReadData,          e.rd);
    end
  end

  initial begin
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
    txn("reset_rd", 2'b00, 2'b00, 4'd0, 16'h0004, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
    rst_cmd = 1'b1;
    txn("add_ovf", 2'b10, 2'b00, 4'd0, 16'h7FFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0);
    txn("beq_eq",  2'b01, 2'b00, 4'd0, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0);
    txn("slt_lt",  2'b11, 2'b00, 4'd5, 16'hFFFE, 16'h0003, 1'b0, 16'h0000, 1'b0, 1'b0);
    txn("slt_ge",  2'b11, 2'b00, 4'd5, 16'h0003, 16'hFFFE, 1'b0, 16'h0000, 1'b0, 1'b0);
    txn("and_r",   2'b10, 2'b10, 4'd0, 16'hF0F0, 16'hFF00, 1'b0, 16'h0000, 1'b0, 1'b0);
    txn("or_r",    2'b10, 2'b11, 4'd0, 16'hF0F0, 16'hFF00, 1'b0, 16'h0000, 1'b0, 1'b0);
    txn("iop_def", 2'b11, 2'b00, 4'd9, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0);
    txn("store",   2'b00, 2'b00, 4'd0, 16'h000A, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 1'b1);
    txn("load",    2'b00, 2'b00, 4'd0, 16'h000A, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
    txn("load_odd",2'b00, 2'b00, 4'd0, 16'h000B, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
    txn("load_wrp",2'b00, 2'b00, 4'd0, 16'h008A, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
    txn("rw_same", 2'b00, 2'b00, 4'd0, 16'h000A, 16'h0000, 1'b0, 16'h1111, 1'b1, 1'b1);
    txn("rw_after",2'b00, 2'b00, 4'd0, 16'h000A, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
    txn("st4",     2'b00, 2'b00, 4'd0, 16'h0004, 16'h0000, 1'b0, 16'h1234, 1'b0, 1'b1);
    txn("ld4",     2'b00, 2'b00, 4'd0, 16'h0004, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
    rst_cmd = 1'b0;
    txn("rst_ld4", 2'b00, 2'b00, 4'd0, 16'h0004, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
    txn("rst_st4", 2'b00, 2'b00, 4'd0, 16'h0004, 16'h0000, 1'b0, 16'h5555, 1'b1, 1'b1);
    rst_cmd = 1'b1;
    txn("post_ld4",2'b00, 2'b00, 4'd0, 16'h0004, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
    txn("post_ldA",2'b00, 2'b00, 4'd0, 16'h000A, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
    for (int i = 0; i < 400; i++) begin
      logic [15:0] ra, rb;
      ra = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom);
      rb = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 7)) : 16'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ra;
      txn("rand", 2'($urandom), 2'($urandom), 4'($urandom_range(3, 8)), ra, rb,
          ($urandom_range(0, 3) == 0), 16'($urandom),
          1'($urandom), ($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge Clock);
    @(posedge Clock);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
